// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared helpers for the pipe_chain register chain.
//                occ_width() - bits needed to count 0..stages valid entries
//                popcount()  - number of set bits in a valid vector
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Widest valid vector popcount() accepts; callers zero-extend to this.
    localparam int c_popcount_max = 64;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    function automatic int popcount(input logic [c_popcount_max-1:0] bits);
        int n;
        n = 0;
        for (int i = 0; i < c_popcount_max; i++) begin
            if (bits[i]) n++;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_chain_if
//  Description : Handshake, control and status bundle of pipe_chain.
//                master : upstream/downstream/control side (testbench, core)
//                slave  : the pipe_chain instance
//                Upstream  : in_valid_i, in_ready_o, in_data_i
//                Downstream: out_valid_o, out_ready_i, out_data_o
//                Control   : stall_i, flush_i, flush_mask_i
//                Status    : stage_valid_o, occupancy_o
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_chain_if
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
);
    localparam int c_occ_w = occ_width(STAGES);

    logic                in_valid_i;
    logic                in_ready_o;
    logic [WIDTH-1:0]    in_data_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [WIDTH-1:0]    out_data_o;
    logic                stall_i;
    logic                flush_i;
    logic [STAGES-1:0]   flush_mask_i;
    logic [STAGES-1:0]   stage_valid_o;
    logic [c_occ_w-1:0]  occupancy_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i, stall_i, flush_i, flush_mask_i,
        input  in_ready_o, out_valid_o, out_data_o, stage_valid_o, occupancy_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i, stall_i, flush_i, flush_mask_i,
        output in_ready_o, out_valid_o, out_data_o, stage_valid_o, occupancy_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : One register stage: a valid bit plus a WIDTH-bit payload.
//                clk_i, rst_i   : clock, asynchronous active-low reset
//                i_en           : stage advances (loads from its source)
//                i_kill         : clears the valid bit after the advance
//                i_valid/i_data : source valid and payload
//                o_valid/o_data : registered valid and payload
//                o_valid_nxt    : next-state valid (feeds occupancy counting)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             i_en,
    input  wire logic             i_kill,
    input  wire logic             i_valid,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic                  o_valid_nxt,
    output logic [WIDTH-1:0]      o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_valid_nxt;

    // Kill wins over the advance so a word entering a flushed stage is dropped.
    assign w_valid_nxt = i_kill ? 1'b0 : (i_en ? i_valid : r_valid);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            // Payload only moves with a real word; bubbles leave it untouched.
            if (i_en && i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_valid_nxt = w_valid_nxt;
    assign o_data      = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_chain
//  Description : STAGES-deep register chain with valid/ready handshake,
//                global stall, per-stage flush and optional bubble collapse.
//                clk_i  : clock, rising edge
//                rst_i  : asynchronous active-low reset
//                bus    : pipe_chain_if slave (handshake, control, status)
//                Stage 0 is the input side, stage STAGES-1 the output side.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STAGES          = 4,
    parameter int BUBBLE_COLLAPSE = 1
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    pipe_chain_if.slave bus
);

    localparam int c_occ_w = occ_width(STAGES);

    logic [STAGES:0]    w_en_chain;
    logic [STAGES-1:0]  w_en;
    logic [STAGES-1:0]  w_kill;
    logic [STAGES-1:0]  w_src_valid;
    logic [STAGES-1:0]  w_valid_q;
    logic [STAGES-1:0]  w_valid_d;
    logic [WIDTH-1:0]   w_src_data [STAGES];
    logic [WIDTH-1:0]   w_data_q   [STAGES];
    logic               w_in_xfer;
    logic [c_occ_w-1:0] r_occupancy;

    // Enable chain, walked from the output side. In collapse mode a stage
    // may load whenever it is empty or its own content moves on, so this is
    // a deliberate combinational ripple from out_ready_i to in_ready_o.
    // Rigid mode uses one shared enable: the whole chain shifts or nothing.
    always_comb begin
        w_en_chain         = '0;
        w_en_chain[STAGES] = bus.out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (BUBBLE_COLLAPSE != 0) begin
                w_en_chain[k] = ~w_valid_q[k] | w_en_chain[k+1];
            end else begin
                w_en_chain[k] = bus.out_ready_i | ~w_valid_q[STAGES-1];
            end
        end
    end

    assign w_en      = w_en_chain[STAGES-1:0] & {STAGES{~bus.stall_i}};
    assign w_kill    = {STAGES{bus.flush_i}} & bus.flush_mask_i;
    assign w_in_xfer = bus.in_valid_i & w_en[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_src_valid[k] = w_in_xfer;
            assign w_src_data[k]  = bus.in_data_i;
        end else begin : g_body
            assign w_src_valid[k] = w_valid_q[k-1];
            assign w_src_data[k]  = w_data_q[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .i_en        (w_en[k]),
            .i_kill      (w_kill[k]),
            .i_valid     (w_src_valid[k]),
            .i_data      (w_src_data[k]),
            .o_valid     (w_valid_q[k]),
            .o_valid_nxt (w_valid_d[k]),
            .o_data      (w_data_q[k])
        );
    end

    // Registered count of next-state valids, so it always matches the
    // stage_valid_o vector that becomes visible after the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= c_occ_w'(popcount(c_popcount_max'(w_valid_d)));
        end
    end

    assign bus.in_ready_o    = w_en[0];
    assign bus.out_valid_o   = w_valid_q[STAGES-1] & ~bus.stall_i;
    assign bus.out_data_o    = w_data_q[STAGES-1];
    assign bus.stage_valid_o = w_valid_q;
    assign bus.occupancy_o   = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_chain
//  Description : Self-checking bench for pipe_chain. A collapse-mode and a
//                rigid-mode instance see identical stimulus. Each has an
//                entry-list reference model (word + position) and an output
//                scoreboard queue drained by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_chain;

    localparam int W = 32;
    localparam int S = 4;

    typedef struct {
        int          pos;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic rst_n;

    pipe_chain_if #(.WIDTH(W), .STAGES(S)) bus0 ();
    pipe_chain_if #(.WIDTH(W), .STAGES(S)) bus1 ();

    pipe_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_COLLAPSE(1)) u_dut_collapse (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0)
    );

    pipe_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_COLLAPSE(0)) u_dut_rigid (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        mq0[$];
    ent_t        mq1[$];
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Whether the entry at position p (p = -1 means the input port) may step
    // forward this cycle. Collapse: some free slot exists beyond p, or the
    // output drains. Rigid: the last slot is free, or the output drains.
    function automatic bit may_move(input ent_t q[$], input int p, input bit collapse,
                                    input bit ordy, input bit st);
        int above;
        bit tail;
        above = 0;
        tail  = 1'b0;
        if (st)   return 1'b0;
        if (ordy) return 1'b1;
        foreach (q[i]) begin
            if (q[i].pos > p)     above++;
            if (q[i].pos == S - 1) tail = 1'b1;
        end
        if (collapse) return above < (S - 1 - p);
        return !tail;
    endfunction

    function automatic logic [3:0] occ_mask(input ent_t q[$]);
        logic [3:0] m;
        m = '0;
        foreach (q[i]) m[q[i].pos] = 1'b1;
        return m;
    endfunction

    // Advance one model by one cycle; returns the expected combinational
    // handshake outputs for the current cycle.
    task automatic model_step(input int d, input bit iv, input logic [31:0] id,
                              input bit ordy, input bit st, input bit fl,
                              input logic [3:0] mk, output bit ir, output bit ov);
        ent_t q[$];
        ent_t nq[$];
        ent_t fq[$];
        ent_t e;
        bit   collapse;
        collapse = (d == 0);
        if (d == 0) q = mq0; else q = mq1;
        ir = may_move(q, -1, collapse, ordy, st);
        ov = !st && (q.size() > 0) && (q[0].pos == S - 1);
        foreach (q[i]) begin
            e = q[i];
            if (may_move(q, e.pos, collapse, ordy, st)) begin
                if (e.pos == S - 1) begin
                    if (d == 0) exp0.push_back(e.data); else exp1.push_back(e.data);
                end else begin
                    e.pos = e.pos + 1;
                    nq.push_back(e);
                end
            end else begin
                nq.push_back(e);
            end
        end
        if (iv && ir) begin
            e.pos  = 0;
            e.data = id;
            nq.push_back(e);
        end
        foreach (nq[i]) begin
            if (!(fl && mk[nq[i].pos])) fq.push_back(nq[i]);
        end
        if (d == 0) mq0 = fq; else mq1 = fq;
    endtask

    task automatic check_state();
        check("stage_valid[collapse]", bus0.stage_valid_o, occ_mask(mq0));
        check("occupancy[collapse]", bus0.occupancy_o, mq0.size());
        if (mq0.size() > 0 && mq0[0].pos == S - 1)
            check("out_data_q[collapse]", bus0.out_data_o, mq0[0].data);
        check("stage_valid[rigid]", bus1.stage_valid_o, occ_mask(mq1));
        check("occupancy[rigid]", bus1.occupancy_o, mq1.size());
        if (mq1.size() > 0 && mq1[0].pos == S - 1)
            check("out_data_q[rigid]", bus1.out_data_o, mq1[0].data);
    endtask

    task automatic drive(input bit iv, input logic [31:0] id, input bit ordy,
                         input bit st, input bit fl, input logic [3:0] mk);
        bus0.in_valid_i = iv;   bus1.in_valid_i = iv;
        bus0.in_data_i  = id;   bus1.in_data_i  = id;
        bus0.out_ready_i = ordy; bus1.out_ready_i = ordy;
        bus0.stall_i = st;      bus1.stall_i = st;
        bus0.flush_i = fl;      bus1.flush_i = fl;
        bus0.flush_mask_i = mk; bus1.flush_mask_i = mk;
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit iv, input logic [31:0] id, input bit ordy,
                         input bit st, input bit fl, input logic [3:0] mk);
        bit ir0, ov0, ir1, ov1;
        check_state();
        drive(iv, id, ordy, st, fl, mk);
        model_step(0, iv, id, ordy, st, fl, mk, ir0, ov0);
        model_step(1, iv, id, ordy, st, fl, mk, ir1, ov1);
        #1;
        check("in_ready[collapse]", bus0.in_ready_o, ir0);
        check("out_valid[collapse]", bus0.out_valid_o, ov0);
        check("in_ready[rigid]", bus1.in_ready_o, ir1);
        check("out_valid[rigid]", bus1.out_valid_o, ov1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 32'h0, ordy, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && (mq0.size() > 0 || mq1.size() > 0); i++) idle(1'b1);
        check("drained[collapse]", mq0.size(), 0);
        check("drained[rigid]", mq1.size(), 0);
    endtask

    // Scoreboard monitors: pop whenever a DUT completes an output transfer.
    always @(negedge clk) begin
        if (bus0.out_valid_o && bus0.out_ready_i) begin
            n_cmp++;
            if (exp0.size() == 0) begin
                n_bad++;
                $display("FAIL out_data[collapse]: got %h, expected no output", bus0.out_data_o);
            end else begin
                logic [31:0] e;
                e = exp0.pop_front();
                if (bus0.out_data_o !== e) begin
                    n_bad++;
                    $display("FAIL out_data[collapse]: got %h, expected %h", bus0.out_data_o, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.out_valid_o && bus1.out_ready_i) begin
            n_cmp++;
            if (exp1.size() == 0) begin
                n_bad++;
                $display("FAIL out_data[rigid]: got %h, expected no output", bus1.out_data_o);
            end else begin
                logic [31:0] e;
                e = exp1.pop_front();
                if (bus1.out_data_o !== e) begin
                    n_bad++;
                    $display("FAIL out_data[rigid]: got %h, expected %h", bus1.out_data_o, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within its time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset stage_valid", bus0.stage_valid_o, 4'b0000);
        check("reset occupancy", bus0.occupancy_o, 0);
        check("reset out_valid", bus1.out_valid_o, 1'b0);
        rst_n = 1'b1;

        // Reset mid-stream: three words in flight, oldest in stage 3.
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 4'h0);
        idle(1'b0);
        check_state();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset stage_valid[collapse]", bus0.stage_valid_o, 4'b0000);
        check("async reset occupancy[collapse]", bus0.occupancy_o, 0);
        check("async reset out_data[collapse]", bus0.out_data_o, 32'h0);
        check("async reset stage_valid[rigid]", bus1.stage_valid_o, 4'b0000);
        check("async reset occupancy[rigid]", bus1.occupancy_o, 0);
        check("async reset out_data[rigid]", bus1.out_data_o, 32'h0);
        mq0.delete(); mq1.delete(); exp0.delete(); exp1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming 0x1..0x8: first word presented after its 4th edge.
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) check("latency not yet valid", bus0.out_valid_o, 1'b0);
            if (i == 5) begin
                check("latency valid", bus0.out_valid_o, 1'b1);
                check("latency data", bus0.out_data_o, 32'h1);
            end
            cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, 4'h0);
        end
        drain();

        // Backpressure: 0xA..0xD fill the chain, 0xE is refused.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA + 32'(i), 1'b0, 1'b0, 1'b0, 4'h0);
        check("full occupancy[collapse]", bus0.occupancy_o, 4);
        check("full in_ready[collapse]", bus0.in_ready_o, 1'b0);
        check("full in_ready[rigid]", bus1.in_ready_o, 1'b0);
        cycle(1'b1, 32'hE, 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 32'hE, 1'b1, 1'b0, 1'b0, 4'h0);
        check("full swap occupancy[collapse]", bus0.occupancy_o, 4);
        drain();

        // Mode contrast: 0x11, gap, 0x22, then hold out_ready low.
        cycle(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 4'h0);
        idle(1'b1);
        cycle(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 4'h0);
        idle(1'b1);
        repeat (3) idle(1'b0);
        check("gap collapsed", bus0.stage_valid_o, 4'b1100);
        check("gap kept rigid", bus1.stage_valid_o, 4'b1010);
        drain();

        // Flush of stages 0 and 1 on a full chain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h33 - 32'(i), 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0011);
        check("flush stage_valid[collapse]", bus0.stage_valid_o, 4'b1100);
        check("flush occupancy[rigid]", bus1.occupancy_o, 2);
        drain();

        // Stall with and without flush on a full chain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 4'h0);
        check("stall hold occupancy", bus0.occupancy_o, 4);
        cycle(1'b1, 32'h98, 1'b1, 1'b1, 1'b1, 4'b1000);
        check("stall flush occupancy[collapse]", bus0.occupancy_o, 3);
        check("stall flush stage_valid[rigid]", bus1.stage_valid_o, 4'b0111);
        drain();

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)));
        end
        drain();
        @(negedge clk);
        check("scoreboard empty[collapse]", exp0.size(), 0);
        check("scoreboard empty[rigid]", exp1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
